// File: rtl/battleship_pkg.sv
//------------------------------------------------------------------------------
// battleship_pkg : shared FSM state, result codes and ship one-hot constants
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

package battleship_pkg;

  typedef enum logic [1:0] {
    ST_IDLE         = 2'd0,
    ST_SCORE        = 2'd1,
    ST_WAIT_RELEASE = 2'd2
  } shot_state_e;

  localparam logic [1:0] c_RES_NONE = 2'b00;
  localparam logic [1:0] c_RES_MISS = 2'b01;
  localparam logic [1:0] c_RES_NEAR = 2'b10;
  localparam logic [1:0] c_RES_HIT  = 2'b11;

  localparam logic [4:0] c_SHIP_NONE       = 5'b00000;
  localparam logic [4:0] c_SHIP_PATROL     = 5'b00001;
  localparam logic [4:0] c_SHIP_SUBMARINE  = 5'b00010;
  localparam logic [4:0] c_SHIP_DESTROYER  = 5'b00100;
  localparam logic [4:0] c_SHIP_BATTLESHIP = 5'b01000;
  localparam logic [4:0] c_SHIP_CARRIER    = 5'b10000;

  localparam logic [6:0] c_SCORE_MAX = 7'd127;

  function automatic logic [6:0] sat_add_score(input logic [6:0] score,
                                               input logic [3:0] cells);
    logic [7:0] sum;
    sum = {1'b0, score} + {4'b0, cells};
    return (sum > {1'b0, c_SCORE_MAX}) ? c_SCORE_MAX : sum[6:0];
  endfunction

  function automatic logic [1:0] encode_result(input logic hit,
                                               input logic near_miss,
                                               input logic miss);
    if (hit)            return c_RES_HIT;
    else if (near_miss) return c_RES_NEAR;
    else if (miss)      return c_RES_MISS;
    else                return c_RES_NONE;
  endfunction

endpackage

`default_nettype wire

// File: rtl/fire_edge.sv
//------------------------------------------------------------------------------
// fire_edge : registers the fire button and flags its rising edge
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module fire_edge (
  input  logic clock,
  input  logic reset,
  input  logic Fire,
  output logic FireEvent
);

  logic FirePrev_q;

  always_ff @(posedge clock) begin
    if (reset) FirePrev_q <= 1'b0;
    else       FirePrev_q <= Fire;
  end

  assign FireEvent = Fire & ~FirePrev_q;

endmodule

`default_nettype wire

// File: rtl/shot_sequencer.sv
//------------------------------------------------------------------------------
// shot_sequencer : accepts one shot per fire press, presents it to the scorer
//                  and accumulates the game counters from the scorer's verdict
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module shot_sequencer
  import battleship_pkg::*;
#(
  parameter int NUM_SHOTS = 20,
  parameter int NUM_BIG   = 2
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       Fire,
  input  logic [3:0] XIn,
  input  logic [3:0] YIn,
  input  logic       BigReq,
  input  logic       Hit,
  input  logic       nearMiss,
  input  logic       Miss,
  input  logic       SomethingIsWrong,
  input  logic [3:0] HitCount,
  input  logic [4:0] BiggestShipHit,
  output logic [3:0] X,
  output logic [3:0] Y,
  output logic       Big,
  output logic [1:0] BigLeft,
  output logic       ScoreThis,
  output logic [4:0] ShotsLeft,
  output logic [6:0] Score,
  output logic [4:0] ShipsEverHit,
  output logic [1:0] LastResult,
  output logic       BadShot,
  output logic       GameOver
);

  shot_state_e state_q, state_d;
  logic [3:0]  X_q, X_d, Y_q, Y_d;
  logic        Big_q, Big_d;
  logic [1:0]  BigLeft_q, BigLeft_d;
  logic [4:0]  ShotsLeft_q, ShotsLeft_d;
  logic [6:0]  Score_q, Score_d;
  logic [4:0]  Ships_q, Ships_d;
  logic [1:0]  LastResult_q, LastResult_d;
  logic        BadShot_q, BadShot_d;
  logic        w_fire_event;
  logic        w_game_over;

  fire_edge u_fire_edge (
    .clock     (clock),
    .reset     (reset),
    .Fire      (Fire),
    .FireEvent (w_fire_event)
  );

  assign w_game_over = (ShotsLeft_q == 5'd0);

  always_comb begin
    state_d      = state_q;
    X_d          = X_q;
    Y_d          = Y_q;
    Big_d        = Big_q;
    BigLeft_d    = BigLeft_q;
    ShotsLeft_d  = ShotsLeft_q;
    Score_d      = Score_q;
    Ships_d      = Ships_q;
    LastResult_d = LastResult_q;
    BadShot_d    = BadShot_q;
    ScoreThis    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (w_fire_event && !w_game_over) begin
          X_d     = XIn;
          Y_d     = YIn;
          Big_d   = BigReq;
          state_d = ST_SCORE;
        end
      end
      ST_SCORE: begin
        ScoreThis = 1'b1;
        state_d   = ST_WAIT_RELEASE;
        if (SomethingIsWrong) begin
          BadShot_d = 1'b1;
        end else begin
          // Guards keep the counters from wrapping even if the scorer misjudges
          if (ShotsLeft_q != 5'd0)           ShotsLeft_d = ShotsLeft_q - 5'd1;
          if (Big_q && (BigLeft_q != 2'd0))  BigLeft_d   = BigLeft_q - 2'd1;
          Score_d      = sat_add_score(Score_q, HitCount);
          Ships_d      = Ships_q | BiggestShipHit;
          LastResult_d = encode_result(Hit, nearMiss, Miss);
          BadShot_d    = 1'b0;
        end
      end
      ST_WAIT_RELEASE: begin
        if (!Fire) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      X_q          <= 4'd0;
      Y_q          <= 4'd0;
      Big_q        <= 1'b0;
      BigLeft_q    <= 2'(NUM_BIG);
      ShotsLeft_q  <= 5'(NUM_SHOTS);
      Score_q      <= 7'd0;
      Ships_q      <= c_SHIP_NONE;
      LastResult_q <= c_RES_NONE;
      BadShot_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      X_q          <= X_d;
      Y_q          <= Y_d;
      Big_q        <= Big_d;
      BigLeft_q    <= BigLeft_d;
      ShotsLeft_q  <= ShotsLeft_d;
      Score_q      <= Score_d;
      Ships_q      <= Ships_d;
      LastResult_q <= LastResult_d;
      BadShot_q    <= BadShot_d;
    end
  end

  assign X            = X_q;
  assign Y            = Y_q;
  assign Big          = Big_q;
  assign BigLeft      = BigLeft_q;
  assign ShotsLeft    = ShotsLeft_q;
  assign Score        = Score_q;
  assign ShipsEverHit = Ships_q;
  assign LastResult   = LastResult_q;
  assign BadShot      = BadShot_q;
  assign GameOver     = w_game_over;

endmodule

`default_nettype wire

// File: tb/tb_shot_sequencer.sv
//------------------------------------------------------------------------------
// tb_shot_sequencer : directed self-checking bench for shot_sequencer
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_shot_sequencer;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       Fire = 1'b0, FireSat = 1'b0;
  logic [3:0] XIn = 4'd0, YIn = 4'd0;
  logic       BigReq = 1'b0;
  logic       Hit = 1'b0, nearMiss = 1'b0, Miss = 1'b0, SomethingIsWrong = 1'b0;
  logic [3:0] HitCount = 4'd0;
  logic [4:0] BiggestShipHit = 5'd0;

  logic [3:0] X, Y, Xs, Ys;
  logic       Big, ScoreThis, BadShot, GameOver;
  logic       Bigs, ScoreThisS, BadShotS, GameOverS;
  logic [1:0] BigLeft, LastResult, BigLeftS, LastResultS;
  logic [4:0] ShotsLeft, ShipsEverHit, ShotsLeftS, ShipsS;
  logic [6:0] Score, ScoreS;

  int vectors = 0;
  int miscompares = 0;

  always #5 clock = ~clock;

  shot_sequencer u_dut (
    .clock(clock), .reset(reset), .Fire(Fire), .XIn(XIn), .YIn(YIn),
    .BigReq(BigReq), .Hit(Hit), .nearMiss(nearMiss), .Miss(Miss),
    .SomethingIsWrong(SomethingIsWrong), .HitCount(HitCount),
    .BiggestShipHit(BiggestShipHit), .X(X), .Y(Y), .Big(Big),
    .BigLeft(BigLeft), .ScoreThis(ScoreThis), .ShotsLeft(ShotsLeft),
    .Score(Score), .ShipsEverHit(ShipsEverHit), .LastResult(LastResult),
    .BadShot(BadShot), .GameOver(GameOver)
  );

  shot_sequencer #(.NUM_SHOTS(31), .NUM_BIG(2)) u_sat (
    .clock(clock), .reset(reset), .Fire(FireSat), .XIn(XIn), .YIn(YIn),
    .BigReq(BigReq), .Hit(Hit), .nearMiss(nearMiss), .Miss(Miss),
    .SomethingIsWrong(SomethingIsWrong), .HitCount(HitCount),
    .BiggestShipHit(BiggestShipHit), .X(Xs), .Y(Ys), .Big(Bigs),
    .BigLeft(BigLeftS), .ScoreThis(ScoreThisS), .ShotsLeft(ShotsLeftS),
    .Score(ScoreS), .ShipsEverHit(ShipsS), .LastResult(LastResultS),
    .BadShot(BadShotS), .GameOver(GameOverS)
  );

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  task automatic set_scorer(input logic h, input logic nm, input logic m, input logic bad,
                            input logic [3:0] hc, input logic [4:0] bsh);
    Hit = h; nearMiss = nm; Miss = m; SomethingIsWrong = bad;
    HitCount = hc; BiggestShipHit = bsh;
  endtask

  // One fire pulse; leaves time at cycle t+2 (counters visible), then caller ticks to idle
  task automatic shoot(input bit sat, input logic [3:0] x, input logic [3:0] y, input logic big);
    XIn = x; YIn = y; BigReq = big;
    if (sat) FireSat = 1'b1; else Fire = 1'b1;
    tick();
    check(sat ? "sat_scorethis" : "scorethis", 32'(sat ? ScoreThisS : ScoreThis), 32'd1);
    Fire = 1'b0; FireSat = 1'b0;
    tick();
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_shots"},   32'(ShotsLeft), 32'd20);
    check({tag, "_bigleft"}, 32'(BigLeft), 32'd2);
    check({tag, "_score"},   32'(Score), 32'd0);
    check({tag, "_xy"},      32'({X, Y}), 32'd0);
    check({tag, "_big"},     32'(Big), 32'd0);
    check({tag, "_st"},      32'(ScoreThis), 32'd0);
    check({tag, "_ships"},   32'(ShipsEverHit), 32'd0);
    check({tag, "_last"},    32'(LastResult), 32'd0);
    check({tag, "_bad"},     32'(BadShot), 32'd0);
    check({tag, "_over"},    32'(GameOver), 32'd0);
  endtask

  initial begin
    int pulses;
    tick(); tick();
    reset = 1'b0;
    check_reset_state("rst");

    // First hit on the carrier
    set_scorer(1, 0, 0, 0, 4'd1, 5'b10000);
    XIn = 4'd3; YIn = 4'd3; Fire = 1'b1;
    check("st_at_t", 32'(ScoreThis), 32'd0);
    tick();
    check("st_at_t1", 32'(ScoreThis), 32'd1);
    check("x_at_t1", 32'({X, Y}), 32'h33);
    Fire = 1'b0;
    tick();
    check("st_at_t2", 32'(ScoreThis), 32'd0);
    check("shots1", 32'(ShotsLeft), 32'd19);
    check("score1", 32'(Score), 32'd1);
    check("ships1", 32'(ShipsEverHit), 32'b10000);
    check("last1", 32'(LastResult), 32'd3);
    tick();

    // Big shot hitting six cells
    set_scorer(1, 0, 0, 0, 4'd6, 5'b01000);
    XIn = 4'd3; YIn = 4'd2; BigReq = 1'b1; Fire = 1'b1;
    tick();
    check("big_st", 32'(ScoreThis), 32'd1);
    check("big_flag", 32'(Big), 32'd1);
    check("big_preleft", 32'(BigLeft), 32'd2);
    Fire = 1'b0;
    tick();
    check("big_left1", 32'(BigLeft), 32'd1);
    check("big_score", 32'(Score), 32'd7);
    check("big_ships", 32'(ShipsEverHit), 32'b11000);
    tick();

    // Second big shot, a miss
    set_scorer(0, 0, 1, 0, 4'd0, 5'd0);
    shoot(0, 4'd5, 4'd5, 1'b1);
    check("big2_left", 32'(BigLeft), 32'd0);
    check("big2_shots", 32'(ShotsLeft), 32'd17);
    check("big2_last", 32'(LastResult), 32'd1);
    tick();

    // Third big shot: scorer rejects it
    set_scorer(0, 0, 1, 1, 4'd0, 5'd0);
    XIn = 4'd6; YIn = 4'd6; BigReq = 1'b1; Fire = 1'b1;
    tick();
    check("big3_preleft", 32'(BigLeft), 32'd0);
    Fire = 1'b0;
    tick();
    check("bad_set", 32'(BadShot), 32'd1);
    check("bad_bigleft", 32'(BigLeft), 32'd0);
    check("bad_shots", 32'(ShotsLeft), 32'd17);
    check("bad_score", 32'(Score), 32'd7);
    check("bad_last", 32'(LastResult), 32'd1);
    tick();

    // Near miss clears BadShot
    set_scorer(0, 1, 1, 0, 4'd0, 5'd0);
    shoot(0, 4'd1, 4'd0, 1'b0);
    check("near_bad", 32'(BadShot), 32'd0);
    check("near_last", 32'(LastResult), 32'd2);
    check("near_shots", 32'(ShotsLeft), 32'd16);
    tick();

    // Fire held for ten cycles
    set_scorer(0, 0, 1, 0, 4'd0, 5'd0);
    pulses = 0;
    Fire = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (ScoreThis) pulses++;
    end
    Fire = 1'b0;
    tick(); tick();
    check("hold_pulses", 32'(pulses), 32'd1);
    check("hold_shots", 32'(ShotsLeft), 32'd15);

    // Run out the remaining shots
    for (int i = 0; i < 14; i++) begin
      shoot(0, 4'(i), 4'd9, 1'b0);
      tick();
    end
    check("pre_over_shots", 32'(ShotsLeft), 32'd1);
    check("pre_over", 32'(GameOver), 32'd0);
    shoot(0, 4'd15, 4'd15, 1'b0);
    check("over_shots", 32'(ShotsLeft), 32'd0);
    check("over_flag", 32'(GameOver), 32'd1);
    tick();
    pulses = 0;
    Fire = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (ScoreThis) pulses++;
    end
    Fire = 1'b0;
    tick();
    check("over_pulses", 32'(pulses), 32'd0);
    check("over_shots2", 32'(ShotsLeft), 32'd0);
    check("over_score", 32'(Score), 32'd7);

    // Reset in the SCORE cycle discards the shot
    reset = 1'b1; tick(); reset = 1'b0;
    set_scorer(1, 0, 0, 0, 4'd5, 5'b00100);
    XIn = 4'd7; YIn = 4'd8; BigReq = 1'b1; Fire = 1'b1;
    tick();
    check("rs_st", 32'(ScoreThis), 32'd1);
    Fire = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_reset_state("rs");
    shoot(0, 4'd2, 4'd2, 1'b0);
    check("rs_after_shots", 32'(ShotsLeft), 32'd19);
    check("rs_after_score", 32'(Score), 32'd5);
    tick();

    // Saturation on the 31-shot instance
    reset = 1'b1; tick(); reset = 1'b0;
    check("sat_rst_shots", 32'(ShotsLeftS), 32'd31);
    set_scorer(1, 0, 0, 0, 4'd9, 5'b00001);
    for (int i = 0; i < 14; i++) begin
      shoot(1, 4'd1, 4'd1, 1'b0);
      tick();
    end
    check("sat_126", 32'(ScoreS), 32'd126);
    shoot(1, 4'd1, 4'd1, 1'b0);
    check("sat_127", 32'(ScoreS), 32'd127);
    tick();
    for (int i = 0; i < 16; i++) begin
      shoot(1, 4'd1, 4'd1, 1'b0);
      tick();
    end
    check("sat_final", 32'(ScoreS), 32'd127);
    check("sat_shots", 32'(ShotsLeftS), 32'd0);
    check("sat_over", 32'(GameOverS), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire

// File: doc/shot_sequencer.md
SHOT_SEQUENCER -- requirements
Module: shot_sequencer

Interface
REQ-001 Parameter NUM_SHOTS, default 20: shots granted per game; range 1..31.
REQ-002 Parameter NUM_BIG, default 2: big shots granted per game; range 0..2.
REQ-003 clock  in  1  sole clock; all state updates on its rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 Fire  in  1  player fire button, already synchronized to clock; level signal.
REQ-006 XIn, YIn  in  4 each  player-selected column and row.
REQ-007 BigReq  in  1  player requests a 3x3 big shot.
REQ-008 Hit, nearMiss, Miss, SomethingIsWrong  in  1 each  combinational results from the downstream scorer for the presented shot.
REQ-009 HitCount  in  4  binary count of cells hit by the presented shot, 0..9.
REQ-010 BiggestShipHit  in  5  one-hot biggest ship hit by the presented shot; 0 means none.
REQ-011 X, Y  out  4 each  registered shot coordinates presented to the scorer.
REQ-012 Big  out  1  registered big-shot flag presented to the scorer.
REQ-013 BigLeft  out  2  big shots remaining; never 2'b11.
REQ-014 ScoreThis  out  1  one-cycle strobe; the presented shot is evaluated in this cycle.
REQ-015 ShotsLeft  out  5  shots remaining.
REQ-016 Score  out  7  accumulated hit cells, saturating.
REQ-017 ShipsEverHit  out  5  sticky OR of every accepted BiggestShipHit.
REQ-018 LastResult  out  2  00 none, 01 miss, 10 near miss, 11 hit; last accepted shot.
REQ-019 BadShot  out  1  high from a rejected shot until the next accepted shot or reset.
REQ-020 GameOver  out  1  high when ShotsLeft == 0.

Function
REQ-021 FSM states: IDLE, SCORE, WAIT_RELEASE; one state per cycle, no other states.
REQ-022 A registered FirePrev SHALL provide edge detect; a fire event is Fire=1 and FirePrev=0.
REQ-023 IDLE: on a fire event with GameOver=0, latch XIn->X, YIn->Y, BigReq->Big; go to SCORE.
REQ-024 IDLE: fire events while GameOver=1 SHALL be ignored; the FSM stays in IDLE.
REQ-025 SCORE: ScoreThis=1 for exactly that cycle; X, Y, Big, BigLeft held stable; always go to WAIT_RELEASE next.
REQ-026 At the end of the SCORE cycle with SomethingIsWrong=1, the shot is rejected: BadShot<=1, and no counter, Score, ShipsEverHit or LastResult changes.
REQ-027 At the end of the SCORE cycle with SomethingIsWrong=0, the shot is accepted with these updates:
- ShotsLeft decrements by 1.
- BigLeft decrements by 1 if Big=1.
- Score += HitCount, saturating at 127.
- ShipsEverHit |= BiggestShipHit.
- LastResult is set from Hit, then nearMiss, then Miss, in that priority.
- BadShot is cleared.
REQ-028 BigLeft presented during SCORE is the pre-decrement value, so the scorer flags Big with BigLeft=0 as invalid.
REQ-029 WAIT_RELEASE: stay until Fire=0, then IDLE; holding Fire SHALL NOT produce a second shot.
REQ-030 Latency: fire event in cycle t, then ScoreThis in cycle t+1, then counters updated and visible in cycle t+2.
REQ-031 ShotsLeft SHALL NOT wrap; GameOver asserts in the cycle ShotsLeft becomes 0.
REQ-032 ScoreThis=0 in every state except SCORE.

Reset
REQ-033 reset SHALL take priority over all other inputs and return the FSM to IDLE.
REQ-034 Reset values:
- ShotsLeft=NUM_SHOTS, BigLeft=NUM_BIG.
- X=Y=0, Big=0, ScoreThis=0, FirePrev=0.
- Score=0, ShipsEverHit=0, LastResult=00, BadShot=0, GameOver=0.
REQ-035 A reset asserted during SCORE SHALL discard that shot; no update is applied.

Structure
REQ-036 The FSM state enum, LastResult codes and ship one-hot constants SHALL live in a shared package, battleship_pkg.
REQ-037 One sub-module, fire_edge (FirePrev register plus edge output), is natural; all else is in shot_sequencer.
REQ-038 Width of ShotsLeft and Score is fixed as above regardless of parameters.

Verification
REQ-039 The bench SHALL cover these directed scenarios:
- Reset, then Fire pulse with XIn=3, YIn=3, scorer Hit=1, HitCount=1, BiggestShipHit=10000: ScoreThis high exactly one cycle at t+1; at t+2 ShotsLeft=19, Score=1, ShipsEverHit=10000, LastResult=11.
- BigReq=1 at X=3, Y=2, HitCount=6: BigLeft 2->1 and Score +6; a third big shot with SomethingIsWrong=1 gives BadShot=1, and BigLeft and ShotsLeft stay unchanged.
- Fire held high for 10 cycles: exactly one ScoreThis pulse, ShotsLeft decrements once.
- 20 accepted shots: GameOver=1 and ShotsLeft=0; a further Fire gives no ScoreThis and no counter change.
- Reset asserted during SCORE: next cycle in IDLE, all outputs at reset values.
- Score saturation with NUM_SHOTS=31 and HitCount=9 every shot: Score stops at 127.
